// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte-master among NREQ requesters,
// with burst locking via Last_i and a watchdog that aborts a stalled transfer.
module spi_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [15:0] TIMEOUT = 16'd2048
) (
  input  logic              Clk_i,
  input  logic              Rst_ni,
  input  logic [NREQ-1:0]   Req_i,
  input  logic [NREQ-1:0]   Last_i,
  input  logic [2*NREQ-1:0] Ss_i,
  input  logic [8*NREQ-1:0] Data_i,
  output logic [NREQ-1:0]   Gnt_o,
  output logic [NREQ-1:0]   Done_o,
  output logic [7:0]        Rdata_o,
  output logic              Err_o,
  output logic              Busy_o,
  output logic              Strobe_o,
  output logic [1:0]        SsOut_o,
  output logic [7:0]        ToXmit_o,
  input  logic              Ready_i,
  input  logic [7:0]        Rcvd_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, STB, WAIT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            last_q, last_d;
  logic [7:0]      xmit_q, xmit_d;
  logic [1:0]      ss_q, ss_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [15:0]     wdog_q, wdog_d;
  logic            ready_q;

  logic [PW-1:0]   win, sel;
  logic            found, accept, rise, timeout, wd_abort;

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && Req_i[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // No acceptance while Done_o pulses, so grant and done never coincide.
  assign sel      = (state_q == HOLD) ? owner_q : win;
  assign accept   = Rst_ni && (done_q == '0) &&
                    (((state_q == IDLE) && found) ||
                     ((state_q == HOLD) && Req_i[owner_q]));
  assign rise     = Ready_i && !ready_q;
  assign timeout  = (wdog_q == TIMEOUT);
  assign wd_abort = timeout && (((state_q == WAIT) && !rise) ||
                                ((state_q == HOLD) && !accept));

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      owner_q <= '0;
      last_q  <= 1'b0;
      xmit_q  <= 8'h00;
      ss_q    <= 2'd0;
      rdata_q <= 8'h00;
      done_q  <= '0;
      wdog_q  <= 16'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      xmit_q  <= xmit_d;
      ss_q    <= ss_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      wdog_q  <= wdog_d;
      ready_q <= Ready_i;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    last_d  = last_q;
    xmit_d  = xmit_q;
    ss_d    = ss_q;
    rdata_d = rdata_q;
    done_d  = '0;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          owner_d = sel;
          xmit_d  = Data_i[8*int'(sel) +: 8];
          ss_d    = Ss_i[2*int'(sel) +: 2];
          last_d  = Last_i[sel];
          state_d = STB;
        end else if (state_q == HOLD) begin
          if (wd_abort) begin
            ptr_d   = owner_q;
            state_d = IDLE;
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
        end
      end
      STB: begin
        wdog_d  = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // Only a rising Ready_i counts; a level left over from before STB is ignored.
        if (rise) begin
          rdata_d         = Rcvd_i;
          done_d[owner_q] = 1'b1;
          if (last_q) begin
            ptr_d   = owner_q;
            state_d = IDLE;
          end else begin
            wdog_d  = 16'd0;
            state_d = HOLD;
          end
        end else if (wd_abort) begin
          ptr_d   = owner_q;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Gnt_o    = accept ? (NREQ'(1) << sel) : '0;
    Err_o    = wd_abort;
    Strobe_o = (state_q == STB);
    Busy_o   = (state_q != IDLE);
    Done_o   = done_q;
    Rdata_o  = rdata_q;
    ToXmit_o = xmit_q;
    SsOut_o  = ss_q;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: per-cycle vector table plus hand-written
// timeout and reset-during-transfer sequences. Master is looped back.
module tb_spi_arbiter;

  logic        Clk_i = 1'b0;
  logic        Rst_ni;
  logic [3:0]  Req_i, Last_i, Gnt_o, Done_o;
  logic [7:0]  Ss_i;
  logic [31:0] Data_i;
  logic [7:0]  Rdata_o, ToXmit_o, Rcvd_i;
  logic        Err_o, Busy_o, Strobe_o, Ready_i;
  logic [1:0]  SsOut_o;

  always #5 Clk_i = ~Clk_i;

  // Requester bytes: r0=11 r1=5A r2=A5 r3=3C; selects: r0=2 r1=3 r2=1 r3=0.
  assign Data_i = 32'h3CA55A11;
  assign Ss_i   = {2'd0, 2'd1, 2'd3, 2'd2};
  assign Rcvd_i = ToXmit_o;

  spi_arbiter #(.NREQ(4), .TIMEOUT(16'd20)) dut (
    .Clk_i(Clk_i), .Rst_ni(Rst_ni), .Req_i(Req_i), .Last_i(Last_i),
    .Ss_i(Ss_i), .Data_i(Data_i), .Gnt_o(Gnt_o), .Done_o(Done_o),
    .Rdata_o(Rdata_o), .Err_o(Err_o), .Busy_o(Busy_o), .Strobe_o(Strobe_o),
    .SsOut_o(SsOut_o), .ToXmit_o(ToXmit_o), .Ready_i(Ready_i), .Rcvd_i(Rcvd_i)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req, last;
    logic       rdy;
    logic [3:0] gnt;
    logic       stb;
    logic [3:0] done;
    logic       err, busy;
    logic [1:0] ss;
    logic [7:0] xmit, rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_run = 0, n_fail = 0;

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] last, logic rdy,
                              logic [3:0] gnt, logic stb, logic [3:0] done, logic busy,
                              logic [1:0] ss, logic [7:0] xmit, logic [7:0] rdata);
    vec_t v;
    v.rst = rst; v.req = req; v.last = last; v.rdy = rdy; v.gnt = gnt; v.stb = stb;
    v.done = done; v.err = 1'b0; v.busy = busy; v.ss = ss; v.xmit = xmit; v.rdata = rdata;
    return v;
  endfunction

  function automatic logic [28:0] outs();
    return {Gnt_o, Strobe_o, Done_o, Err_o, Busy_o, SsOut_o, ToXmit_o, Rdata_o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(logic [3:0] req, logic [3:0] last, logic rdy);
    @(posedge Clk_i); #1;
    Req_i = req; Last_i = last; Ready_i = rdy;
    @(negedge Clk_i);
  endtask

  logic [7:0] dat [4] = '{8'h11, 8'h5A, 8'hA5, 8'h3C};
  logic [1:0] ssv [4] = '{2'd2, 2'd3, 2'd1, 2'd0};

  initial begin
    logic [7:0] pr, px;
    logic [1:0] ps;
    logic [3:0] oh;
    int n;
    bit seen_done;
    Rst_ni = 1'b0; Req_i = '0; Last_i = '0; Ready_i = 1'b0;
    repeat (2) @(posedge Clk_i);

    // Reset, then single byte from requester 2
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'b0100, 4'b1111, 0, 4'b0100, 0, 4'b0000, 0, 2'd0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 4'b0000, 1, 2'd1, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0000, 1, 2'd1, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 1, 2'd1, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0100, 0, 2'd1, 8'hA5, 8'hA5));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 2'd1, 8'hA5, 8'hA5));
    // Fairness from reset: grants 0,1,2,3,0 with all requesting
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 8'h00, 8'h00));
    pr = 8'h00; px = 8'h00; ps = 2'd0;
    for (int g = 0; g < 5; g++) begin
      int i;
      i = g % 4;
      oh = 4'b0001 << i;
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, oh, 0, 4'b0000, 0, ps, px, pr));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 4'b0000, 1, ssv[i], dat[i], pr));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 1, ssv[i], dat[i], pr));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, oh, 0, ssv[i], dat[i], dat[i]));
      pr = dat[i]; px = dat[i]; ps = ssv[i];
    end
    // Burst lock: requester 1 sends 3 bytes while requester 3 waits
    for (int b = 0; b < 3; b++) begin
      logic [3:0] lst;
      lst = (b == 2) ? 4'b1010 : 4'b1000;
      vecs.push_back(mk(0, 4'b1010, lst, 0, 4'b0010, 0, 4'b0000, b != 0, (b == 0) ? 2'd2 : 2'd3,
                        (b == 0) ? 8'h11 : 8'h5A, (b == 0) ? 8'h11 : 8'h5A));
      vecs.push_back(mk(0, 4'b1010, lst, 0, 4'b0000, 1, 4'b0000, 1, 2'd3, 8'h5A,
                        (b == 0) ? 8'h11 : 8'h5A));
      vecs.push_back(mk(0, 4'b1010, lst, 1, 4'b0000, 0, 4'b0000, 1, 2'd3, 8'h5A,
                        (b == 0) ? 8'h11 : 8'h5A));
      vecs.push_back(mk(0, 4'b1010, lst, 0, 4'b0000, 0, 4'b0010, b != 2, 2'd3, 8'h5A, 8'h5A));
    end
    vecs.push_back(mk(0, 4'b1010, 4'b1010, 0, 4'b1000, 0, 4'b0000, 0, 2'd3, 8'h5A, 8'h5A));
    vecs.push_back(mk(0, 4'b0000, 4'b1010, 0, 4'b0000, 1, 4'b0000, 1, 2'd0, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 4'b0000, 4'b1010, 1, 4'b0000, 0, 4'b0000, 1, 2'd0, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 4'b0000, 4'b1010, 0, 4'b0000, 0, 4'b1000, 0, 2'd0, 8'h3C, 8'h3C));
    // Stale Ready: high through STB and WAIT entry, completes only on a fresh edge
    vecs.push_back(mk(0, 4'b0001, 4'b1111, 1, 4'b0001, 0, 4'b0000, 0, 2'd0, 8'h3C, 8'h3C));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 1, 4'b0000, 1, 2'd2, 8'h11, 8'h3C));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 1, 2'd2, 8'h11, 8'h3C));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 1, 2'd2, 8'h11, 8'h3C));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0000, 1, 2'd2, 8'h11, 8'h3C));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 1, 2'd2, 8'h11, 8'h3C));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0001, 0, 2'd2, 8'h11, 8'h11));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 2'd2, 8'h11, 8'h11));

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      @(posedge Clk_i); #1;
      Rst_ni = ~v.rst; Req_i = v.req; Last_i = v.last; Ready_i = v.rdy;
      @(negedge Clk_i);
      check($sformatf("vec%0d", k), 32'(outs()),
            32'({v.gnt, v.stb, v.done, v.err, v.busy, v.ss, v.xmit, v.rdata}));
    end

    // Timeout: owner 1, Ready stuck low; Err_o expected on WAIT cycle 20
    step(4'b0010, 4'b1111, 0);
    check("to_gnt", 32'(Gnt_o), 32'h2);
    step(4'b0000, 4'b1111, 0);
    check("to_stb", 32'(Strobe_o), 32'h1);
    n = -1; seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      step(4'b0000, 4'b1111, 0);
      if (Done_o != 0) seen_done = 1;
      if (Err_o) begin n = c; break; end
    end
    check("to_cycles", 32'(n), 32'd20);
    check("to_nodone", 32'(seen_done), 32'd0);
    check("to_err_gnt", 32'({Gnt_o, Busy_o}), 32'h1);
    step(4'b1111, 4'b1111, 0);
    check("to_next_gnt", 32'({Gnt_o, Busy_o, Err_o}), 32'({4'b0100, 1'b0, 1'b0}));
    step(4'b0000, 4'b1111, 0);
    step(4'b0000, 4'b1111, 1);
    step(4'b0000, 4'b1111, 0);
    check("to_recover_done", 32'({Done_o, Rdata_o}), 32'({4'b0100, 8'hA5}));

    // Reset during WAIT: outputs cleared immediately, no done or err afterward
    step(4'b1111, 4'b1111, 0);
    check("rw_gnt", 32'(Gnt_o), 32'h8);
    step(4'b1111, 4'b1111, 0);
    step(4'b1111, 4'b1111, 0);
    check("rw_wait", 32'({Busy_o, Strobe_o}), 32'h2);
    @(posedge Clk_i); #1;
    Rst_ni = 1'b0; Ready_i = 1'b1;
    #1 check("rw_async", 32'(outs()), 32'h0);
    @(negedge Clk_i);
    check("rw_held", 32'(outs()), 32'h0);
    @(posedge Clk_i); #1;
    check("rw_edge", 32'({Done_o, Err_o}), 32'h0);
    Rst_ni = 1'b1; Req_i = 4'b1111; Ready_i = 1'b0;
    @(negedge Clk_i);
    check("rw_first_gnt", 32'(Gnt_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 16'd2048: watchdog limit in Clk_i cycles.
REQ-003 Clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 Rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 Req_i  in  NREQ  per-requester byte request, level.
REQ-006 Last_i  in  NREQ  per-requester flag: the offered byte ends the burst.
REQ-007 Ss_i  in  2*NREQ  per-requester slave select; slice [2i+1:2i] belongs to requester i.
REQ-008 Data_i  in  8*NREQ  per-requester transmit byte; slice [8i+7:8i] belongs to requester i.
REQ-009 Gnt_o  out  NREQ  one-hot, one-cycle pulse: byte accepted and latched.
REQ-010 Done_o  out  NREQ  one-hot, one-cycle pulse: byte finished, Rdata_o valid.
REQ-011 Rdata_o  out  8  received byte of the most recent completed transfer.
REQ-012 Err_o  out  1  one-cycle pulse on watchdog abort.
REQ-013 Busy_o  out  1  high whenever state is not IDLE.
REQ-014 Strobe_o  out  1  to SPI master: start one byte transfer.
REQ-015 SsOut_o  out  2  to SPI master: slave select of the owner.
REQ-016 ToXmit_o  out  8  to SPI master: latched transmit byte.
REQ-017 Ready_i  in  1  from SPI master: level, rises when a byte completes, stays high until the next transfer's first half-bit.
REQ-018 Rcvd_i  in  8  from SPI master: received shift register.

Function
REQ-019 FSM states SHALL be IDLE, STB, WAIT, HOLD.
REQ-020 Round-robin pointer ptr SHALL point to the last owner; the search SHALL start at (ptr+1) mod NREQ and select the first requester with Req_i high.
REQ-021 In IDLE with any Req_i high, the block SHALL latch owner, Ss_i, Data_i and Last_i slices of the winner, assert Gnt_o[owner] combinationally that cycle, and go to STB.
REQ-022 In STB, Strobe_o SHALL be 1 for exactly one cycle, then go to WAIT; Strobe_o SHALL be 0 in all other states.
REQ-023 ToXmit_o and SsOut_o SHALL be registered copies of the latched data and select, stable from STB until the next acceptance.
REQ-024 Completion SHALL be detected only on a Ready_i rising edge (Ready_i=1 and registered ready_q=0), never on level, so a stale high Ready_i after STB is ignored.
REQ-025 On completion in WAIT: Rdata_o <= Rcvd_i, Done_o[owner] pulses one cycle later (aligned with valid Rdata_o); if latched Last=1, go IDLE and set ptr=owner; else go HOLD (locked).
REQ-026 In HOLD, only Req_i[owner] SHALL be considered; if high, accept as in REQ-021 (same owner, Gnt_o[owner], go STB); all other requests SHALL be ignored until the lock is released.
REQ-027 Watchdog SHALL be a 16-bit counter cleared on entry to WAIT or HOLD and incremented each cycle in those states.
REQ-028 When the watchdog equals TIMEOUT, the block SHALL pulse Err_o, not pulse Done_o, set ptr=owner, and go to IDLE.
REQ-029 A completion edge and a timeout in the same cycle SHALL resolve as completion.
REQ-030 Gnt_o, Done_o and Err_o SHALL never be asserted in the same cycle.
REQ-031 Busy_o SHALL be 0 only in IDLE.
REQ-032 Latency: request in IDLE to Strobe_o is 1 cycle; Ready_i edge to Done_o is 1 cycle.

Reset
REQ-033 On Rst_ni low: state IDLE, ptr=NREQ-1, ready_q=0, watchdog=0, owner=0, Strobe_o=0, Gnt_o=0, Done_o=0, Err_o=0, Busy_o=0, Rdata_o=8'h00, ToXmit_o=8'h00, SsOut_o=2'd0.
REQ-034 Reset asserted mid-transfer SHALL abort immediately with no Done_o or Err_o; the first grant after reset SHALL go to requester 0 if it requests.

Verification
REQ-035 Single byte: Req_i[2]=1, Data=8'hA5, Ss=2'd1, Last=1, master looped back -> Gnt_o=4'b0100, Strobe_o one cycle later, SsOut_o=2'd1, ToXmit_o=8'hA5, Done_o[2] and Rdata_o=8'hA5 after the Ready_i edge, then IDLE.
REQ-036 Fairness: Req_i=4'b1111 held, all Last=1 -> grant order 0,1,2,3,0, each grant only after the previous Done_o.
REQ-037 Burst lock: requester 1 sends 3 bytes (Last on third) while Req_i[3]=1 -> requester 3 granted only after requester 1's third Done_o.
REQ-038 Stale Ready: Ready_i held high through STB and WAIT entry -> no Done_o until Ready_i falls and rises again.
REQ-039 Timeout: TIMEOUT=16'd20, Ready_i stuck low after Strobe_o -> Err_o pulse 20 cycles after WAIT entry, no Done_o, IDLE, next grant to owner+1.
REQ-040 Reset mid-WAIT -> all outputs at REQ-033 values the same cycle, no Done_o or Err_o.
